// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing for the 5-stage RV32 core with MAC.
// Resolves load-use hazards, taken-branch flushes and multi-cycle multiplies
// that the forwarding unit cannot cover.
// Optional macro HAZ_PERF_EN enables the stall/flush performance counters;
// when it is undefined both counter ports read constant 0.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned REG_AW  = 5
) (
  input  logic              clk,
  input  logic              res,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_mul,
  input  logic              branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              ifid_flush,
  output logic              mul_start,
  output logic              mul_done,
  output logic              busy,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_LAT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;

  // Load in EX writes a register the ID instruction reads; x0 never hazards.
  assign load_use = id_valid && ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // State and multiply countdown; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_mul) begin
            state <= MUL_BUSY;
            cnt   <= CNT_START;
          end
        end
        MUL_BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stall/bubble/flush decode from state, countdown and hazard inputs.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    mul_start    = 1'b0;
    mul_done     = 1'b0;
    busy         = 1'b0;
    if (!res) begin
      unique case (state)
        RUN: begin
          if (ex_mul) begin
            mul_start    = 1'b1;
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MUL_BUSY: begin
          busy = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            mul_done = 1'b1;
          end else begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating counts of pc stall cycles and if_id flushes.
  always_ff @(posedge clk) begin
    if (res) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core with accumulator/MAC extension.
- Detects load-use hazards, flushes on taken branches, and holds EX while the iterative multiplier runs for MUL_LAT cycles.
- Drives stall, bubble and flush enables into the pc register and the if_id, id_ex and ex_mem pipeline registers.
- Sits beside the forwarding unit and covers only hazards that forwarding cannot resolve.

Parameters:
- MUL_LAT, 4, cycles the multiply occupies EX; legal range 2..15.
- REG_AW, 5, register-number width.

Ports:
- clk  in  1  clock.
- res  in  1  synchronous, active-high reset.
- id_valid  in  1  instruction in ID is real (not a bubble).
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  EX destination register.
- ex_memread  in  1  EX instruction is a load.
- ex_mul  in  1  EX instruction is a multiply.
- branch_taken  in  1  branch resolved taken in EX.
- pc_stall  out  1  hold pc.
- ifid_stall  out  1  hold if_id.
- idex_stall  out  1  hold id_ex.
- idex_bubble  out  1  load NOP into id_ex.
- exmem_bubble  out  1  load NOP into ex_mem.
- ifid_flush  out  1  load NOP into if_id.
- mul_start  out  1  one-cycle pulse: multiplier begins.
- mul_done  out  1  one-cycle pulse: result valid in EX.
- busy  out  1  FSM in MUL_BUSY.
- stall_cycles  out  32  perf counter (see optional feature).
- flush_count  out  16  perf counter (see optional feature).

Behaviour:
- State register and counters are clocked on posedge clk. All outputs other than the perf counters are combinational from state, cnt and inputs.
- While res=1 every output is 0. Next state is RUN, cnt=0 and perf counters are 0. This applies to reset mid-operation too: a multiply in flight is abandoned with no mul_done.
- States: RUN(0), MUL_BUSY(1). cnt is 4 bits.
- In RUN, the first matching priority applies:
  1. ex_mul=1: mul_start=1, pc_stall=ifid_stall=idex_stall=1, exmem_bubble=1. Next state MUL_BUSY, cnt<=MUL_LAT-1.
  2. branch_taken=1: ifid_flush=1, idex_bubble=1, no stalls. Stay in RUN.
  3. Load-use: id_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
     - pc_stall=ifid_stall=1, idex_bubble=1 for exactly that cycle. Stay in RUN.
     - The next cycle re-evaluates naturally, because ex_rd is then the bubble.
  4. Otherwise all outputs are 0.
- In MUL_BUSY, cnt decrements each cycle:
  - cnt>1: pc_stall=ifid_stall=idex_stall=1, exmem_bubble=1, busy=1.
  - cnt==1: mul_done=1, busy=1, all stalls and bubbles 0. Next state RUN, cnt<=0. The multiply advances to MEM on this edge.
  - branch_taken and load-use inputs are ignored in MUL_BUSY. ID is frozen, so the hazard is re-evaluated in the following RUN cycle.
- A multiply occupies EX for exactly MUL_LAT cycles: the start cycle plus MUL_LAT-1 busy cycles. Stalls are asserted for MUL_LAT-1 of those cycles.
- Back-to-back multiplies: the RUN cycle after mul_done sees the next ex_mul and restarts immediately. There are no idle cycles.
- The invariants hold in every cycle: ifid_flush and ifid_stall are never both 1, and idex_bubble and idex_stall are never both 1.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined:
  - stall_cycles increments by 1 in every cycle with pc_stall=1, saturating at 32'hFFFF_FFFF.
  - flush_count increments on every cycle with ifid_flush=1, saturating at 16'hFFFF.
  - Both counters are registered and clear on res.
- Undefined: both ports are tied to constant 0 and no counter flops are inferred.

Test Plan:
- Reset mid-multiply: ex_mul=1 for 2 cycles, then res=1 -> next cycle state RUN, all outputs 0, no mul_done ever issued.
- Load-use: ex_memread=1, ex_rd=5, id_valid=1, id_rs1=5 -> exactly one cycle with pc_stall=ifid_stall=idex_bubble=1.
- Load-use corner cases:
  - Same as above with ex_rd=0 -> no stall.
  - id_rs2=5 with id_uses_rs2=0 -> no stall.
- Multiply, MUL_LAT=4, single ex_mul:
  - mul_start in cycle 0.
  - Stalls in cycles 0-2.
  - mul_done in cycle 3 with stalls 0.
  - Back-to-back ex_mul gives mul_start again in cycle 4.
- Priority: branch_taken=1 together with a load-use match in RUN -> ifid_flush=1, idex_bubble=1, pc_stall=0. Repeat with MUL_BUSY active -> branch ignored.
- HAZ_PERF_EN defined: 3 load-use stalls + 1 multiply (MUL_LAT=4) + 2 taken branches -> stall_cycles=6, flush_count=2. With the macro undefined, both read 0.
